// File: rtl/y_sram_pkg.sv
// Shared constants, element type and line-slicing helper for the Y-SRAM reader.
package y_sram_pkg;

  localparam int ADDR_W         = 11;
  localparam int DATA_W         = 256;
  localparam int ELEM_W         = 48;
  localparam int ELEMS_PER_WORD = 5;
  localparam int RD_LAT         = 1;
  localparam int IDX_W          = 3;
  localparam int SLOTS          = 2;

  // Complex element: real part in the upper half, imaginary part in the lower half.
  typedef struct packed {
    logic [ELEM_W/2-1:0] re;
    logic [ELEM_W/2-1:0] im;
  } cplx_t;

  // Extract element k of a line. The line is zero-padded to a power-of-two
  // element count so that any k the index width can express stays in range.
  function automatic cplx_t slice_elem(input logic [DATA_W-1:0] line,
                                       input logic [IDX_W-1:0]  k);
    logic [(2**IDX_W)*ELEM_W-1:0] padded;
    padded = {{((2**IDX_W)*ELEM_W-DATA_W){1'b0}}, line};
    return padded[k*ELEM_W +: ELEM_W];
  endfunction

endpackage

// File: rtl/y_line_buffer.sv
// Two-slot ping-pong line store. Lines are captured in issue order into the
// write slot and drained element by element from the head slot.
module y_line_buffer
  import y_sram_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              capture,
  input  logic              capture_last,
  input  logic [DATA_W-1:0] line_in,
  input  logic              pop,
  output logic [1:0]        free_slots,
  output logic              out_valid,
  output cplx_t             out_elem,
  output logic              out_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS_PER_WORD - 1);

  logic [DATA_W-1:0] slot_data [SLOTS];
  logic [SLOTS-1:0]  slot_full;
  logic [SLOTS-1:0]  slot_last;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [IDX_W-1:0]  idx;

  // Slot fill on capture, element index advance and slot release on pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SLOTS; i++) slot_data[i] <= '0;
      slot_full <= '0;
      slot_last <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      idx       <= '0;
    end else begin
      if (capture) begin
        slot_data[wr_ptr] <= line_in;
        slot_full[wr_ptr] <= 1'b1;
        slot_last[wr_ptr] <= capture_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        if (idx == LAST_IDX) begin
          slot_full[rd_ptr] <= 1'b0;
          rd_ptr            <= ~rd_ptr;
          idx               <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  // Head-slot element mux and occupancy report, all from registered state.
  always_comb begin
    out_valid  = slot_full[rd_ptr];
    out_elem   = out_valid ? slice_elem(slot_data[rd_ptr], idx) : '0;
    out_last   = out_valid && slot_last[rd_ptr] && (idx == LAST_IDX);
    free_slots = 2'(SLOTS) - ({1'b0, slot_full[0]} + {1'b0, slot_full[1]});
  end

endmodule

// File: rtl/y_sram_reader.sv
// Y-SRAM read-out engine: walks a contiguous line range, keeps at most two
// lines buffered or in flight, and streams 48-bit complex elements.
module y_sram_reader
  import y_sram_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ReadAddress1,
  input  logic [DATA_W-1:0] ReadBus1,
  output logic [ELEM_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] words_rem;
  logic [RD_LAT:0]   tag_vld;
  logic [RD_LAT:0]   tag_last;

  logic              issue;
  logic              issue_last;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W-1:0] issue_rem;
  logic [3:0]        in_flight;
  logic              credit_ok;
  logic [1:0]        free_slots;
  logic              buf_valid;
  logic              buf_last;
  cplx_t             buf_elem;
  logic              pop;

  assign pop       = buf_valid && out_ready;
  assign out_valid = buf_valid;
  assign out_last  = buf_last;
  assign out_data  = buf_elem;

  // Count reads still travelling through the SRAM so a slot is never oversubscribed.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i <= RD_LAT; i++) in_flight = in_flight + 4'(tag_vld[i]);
    credit_ok = ({2'b00, free_slots} > in_flight);
  end

  // Next-state, read-issue decision and status outputs. A read decided here
  // appears on ReadAddress1 in the following cycle.
  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    issue_addr = addr_q;
    issue_rem  = words_rem;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          issue_addr = base_addr;
          issue_rem  = num_words;
          if (num_words != '0) begin
            state_d = ST_RUN;
            issue   = 1'b1;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (words_rem != '0 && credit_ok) issue = 1'b1;
        if (pop && buf_last) state_d = ST_FIN;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    issue_last = (issue_rem == ADDR_W'(1));
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Address and remaining-line counters, registered read address and tag pipe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q       <= '0;
      words_rem    <= '0;
      ReadAddress1 <= '0;
      tag_vld      <= '0;
      tag_last     <= '0;
    end else begin
      tag_vld  <= {tag_vld[RD_LAT-1:0], issue};
      tag_last <= {tag_last[RD_LAT-1:0], issue && issue_last};
      if (issue) begin
        ReadAddress1 <= issue_addr;
        addr_q       <= issue_addr + ADDR_W'(1);
        words_rem    <= issue_rem - ADDR_W'(1);
      end
    end
  end

  y_line_buffer u_line_buffer (
    .clock        (clock),
    .reset        (reset),
    .capture      (tag_vld[RD_LAT]),
    .capture_last (tag_last[RD_LAT]),
    .line_in      (ReadBus1),
    .pop          (pop),
    .free_slots   (free_slots),
    .out_valid    (buf_valid),
    .out_elem     (buf_elem),
    .out_last     (buf_last)
  );

endmodule

// File: tb/tb_y_sram_reader.sv
// Scoreboard bench for y_sram_reader: an SRAM array model, a line-to-element
// reference queue and an independent output monitor.
module tb_y_sram_reader;
  import y_sram_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] num_words = '0;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ReadAddress1;
  logic [DATA_W-1:0] ReadBus1 = '0;
  logic [ELEM_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_last;

  logic [DATA_W-1:0] mem [2048];
  logic [ELEM_W:0]   exp_q [$];
  int                checks = 0;
  int                errors = 0;
  int                ready_mode = 0;
  logic              zl_due = 1'b0;

  logic              done_due = 1'b0;
  logic              have_stall = 1'b0;
  logic [ELEM_W:0]   stall_val = '0;
  logic [ELEM_W:0]   mon_exp;

  always #5 clock = ~clock;

  y_sram_reader dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .num_words    (num_words),
    .busy         (busy),
    .done         (done),
    .ReadAddress1 (ReadAddress1),
    .ReadBus1     (ReadBus1),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last)
  );

  // One-cycle-latency SRAM read port.
  always @(posedge clock) ReadBus1 <= mem[ReadAddress1];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: every line of the range contributes five elements in index order.
  task automatic pushExpected(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n);
    for (int w = 0; w < int'(n); w++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] ln;
      a  = b + ADDR_W'(w);
      ln = mem[a];
      for (int k = 0; k < ELEMS_PER_WORD; k++)
        exp_q.push_back({ln[k*ELEM_W +: ELEM_W], (w == int'(n) - 1) && (k == ELEMS_PER_WORD - 1)});
    end
  endtask

  // Issue a start in cycle 0; returns 1 time unit into cycle 1.
  task automatic applyStimulus(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n);
    pushExpected(b, n);
    @(posedge clock); #1;
    base_addr = b;
    num_words = n;
    start     = 1'b1;
    @(posedge clock); #1;
    start     = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clock); #1;
      if (exp_q.size() == 0 && !busy && !done) break;
    end
    checkOutput("transfer_complete", 64'({32'(exp_q.size()), busy}), 64'(0));
    exp_q.delete();
  endtask

  // Downstream ready pattern generator.
  initial forever begin
    @(posedge clock); #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      2:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every accepted beat and polices done and stalls.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      done_due   = 1'b0;
      have_stall = 1'b0;
    end else begin
      if (done_due || zl_due) begin
        checkOutput("done_pulse", 64'({done, busy}), 64'(2'b10));
        done_due = 1'b0;
      end else if (done) begin
        checkOutput("spurious_done", 64'(done), 64'(0));
      end
      if (have_stall) begin
        checkOutput("stall_hold", 64'({out_valid, out_data, out_last}), 64'({1'b1, stall_val}));
        have_stall = 1'b0;
      end
      if (out_valid && !out_ready) begin
        have_stall = 1'b1;
        stall_val  = {out_data, out_last};
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("extra_beat", 64'(1), 64'(0));
        end else begin
          mon_exp = exp_q.pop_front();
          checkOutput("beat", 64'({out_data, out_last}), 64'(mon_exp));
          if (mon_exp[0]) done_due = 1'b1;
        end
      end
    end
  end

  initial begin
    logic [ADDR_W-1:0] ra_prev;
    logic [ADDR_W-1:0] ra_seq [$];
    logic [DATA_W-1:0] line;
    int                gaps;

    for (int a = 0; a < 2048; a++)
      for (int j = 0; j < 8; j++) mem[a][j*32 +: 32] = $urandom();

    #2;
    checkOutput("reset_outputs", 64'({busy, done, out_valid, out_last, out_data, ReadAddress1}), 64'(0));
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Zero-length transfer: done in cycle 1, nothing else moves.
    applyStimulus(11'h123, 11'd0);
    zl_due = 1'b1;
    checkOutput("zero_len_c1", 64'({busy, out_valid, ReadAddress1}), 64'(0));
    @(negedge clock); #1 zl_due = 1'b0;
    @(posedge clock); #1;
    checkOutput("zero_len_c2", 64'({done, busy, out_valid, ReadAddress1}), 64'(0));

    // Streaming four lines from address 0 with ready held high.
    ready_mode = 0;
    applyStimulus(11'h000, 11'd4);
    ra_prev = ReadAddress1;
    gaps    = 0;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      if (cyc > 1) begin
        @(posedge clock); #1;
      end
      if (cyc == 1) begin
        checkOutput("stream_ra_c1", 64'(ReadAddress1), 64'(0));
        checkOutput("stream_busy_c1", 64'(busy), 64'(1));
      end
      if (cyc == 2) checkOutput("stream_valid_c2", 64'(out_valid), 64'(0));
      if (cyc == 3) checkOutput("stream_valid_c3", 64'(out_valid), 64'(1));
      if (cyc >= 3 && cyc <= 22 && !out_valid) gaps++;
      if (ReadAddress1 != ra_prev) begin
        ra_seq.push_back(ReadAddress1);
        ra_prev = ReadAddress1;
      end
    end
    checkOutput("stream_gaps", 64'(gaps), 64'(0));
    checkOutput("stream_ra_count", 64'(ra_seq.size()), 64'(3));
    for (int i = 0; i < ra_seq.size(); i++)
      checkOutput("stream_ra_seq", 64'(ra_seq[i]), 64'(i + 1));
    waitIdle(200);

    // Single line with known element values.
    line = '0;
    for (int k = 0; k < ELEMS_PER_WORD; k++)
      line[k*ELEM_W +: ELEM_W] = {24'(2*k + 1), 24'(2*k + 2)};
    mem[11'h010] = line;
    applyStimulus(11'h010, 11'd1);
    waitIdle(200);

    // Address wrap from the top of the array.
    applyStimulus(11'h7FF, 11'd2);
    checkOutput("wrap_first_addr", 64'(ReadAddress1), 64'(11'h7FF));
    for (int i = 0; i < 20 && ReadAddress1 == 11'h7FF; i++) begin
      @(posedge clock); #1;
    end
    checkOutput("wrap_second_addr", 64'(ReadAddress1), 64'(0));
    waitIdle(200);

    // Backpressure: no consumption limits lookahead to two lines, then alternate.
    ready_mode = 3;
    applyStimulus(11'h200, 11'd4);
    repeat (12) @(posedge clock);
    #1;
    checkOutput("lookahead_ra", 64'(ReadAddress1), 64'(11'h201));
    checkOutput("lookahead_valid", 64'(out_valid), 64'(1));
    ready_mode = 1;
    waitIdle(200);

    // A start while busy must not disturb the running transfer.
    ready_mode = 2;
    applyStimulus(11'h400, 11'd3);
    repeat (4) @(posedge clock);
    #1;
    base_addr = 11'h050;
    num_words = 11'd5;
    start     = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    waitIdle(200);

    // Asynchronous reset mid-stream, then a fresh transfer.
    ready_mode = 0;
    applyStimulus(11'h300, 11'd4);
    repeat (6) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_reset", 64'({busy, done, out_valid, out_last, out_data, ReadAddress1}), 64'(0));
    exp_q.delete();
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    checkOutput("post_reset_idle", 64'({busy, done, out_valid}), 64'(0));
    applyStimulus(11'h345, 11'd3);
    waitIdle(200);

    // Randomized transfers.
    for (int t = 0; t < 10; t++) begin
      ready_mode = $urandom_range(0, 2);
      applyStimulus(ADDR_W'($urandom_range(0, 2047)), ADDR_W'($urandom_range(1, 6)));
      waitIdle(300);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
